// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage.
// A load or store parks the stage in a three-state handshake FSM
// (IDLE -> REQ -> DONE) and freezes upstream until the access retires.
// Instructions that do not touch memory pass straight through in one cycle.
// Optional feature: define MEM_TIMEOUT_EN to abort a request that gets no
// dmem_ack within TIMEOUT_CYCLES REQ cycles. The abort pulses mem_err and
// suppresses the register write.
// Handshake: dmem_req is held high for every REQ cycle and the access
// completes on the first rising edge that samples dmem_ack high while
// dmem_req is high. dmem_ack is ignored at all other times.
module mem_stage #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  br,
  input  logic [3:0]  br_cond,
  input  logic [3:0]  alu_cond,
  input  logic [31:0] alu,
  input  logic [31:0] adder,
  input  logic [31:0] writedata,
  input  logic [3:0]  rd,
  input  logic [10:0] signals,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall,
  output logic        pc_src,
  output logic [31:0] br_target,
  output logic [31:0] wb_data,
  output logic [3:0]  wb_rd,
  output logic        wb_we,
  output logic        wb_valid,
  output logic [5:0]  wb_sig,
  output logic [3:0]  wb_br_cond,
  output logic        mem_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      next_state;
  logic        memop;
  logic        timeout_hit;
  logic [31:0] rdata_q;

  assign memop = signals[0] | signals[1];

  // The DONE cycle does not stall. The retiring write happens on that same edge.
  assign stall      = ((state == IDLE) && memop) || (state == REQ);
  assign dmem_req   = (state == REQ);
  assign dmem_addr  = alu;
  assign dmem_wdata = writedata;
  assign dmem_we    = dmem_req & signals[1];

  assign pc_src    = signals[4] & (|(br & alu_cond)) & ~stall;
  assign br_target = adder;

`ifdef MEM_TIMEOUT_EN
  logic [7:0] to_cnt;
  logic       err_q;

  // Reaching TIMEOUT_CYCLES-1 in a REQ cycle without ack means this is the last REQ cycle allowed.
  assign timeout_hit = (to_cnt == 8'(TIMEOUT_CYCLES - 1));

  // Count REQ cycles spent waiting. The count restarts each time a new request begins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= 8'd0;
    end else if ((state == IDLE) && memop) begin
      to_cnt <= 8'd0;
    end else if ((state == REQ) && !dmem_ack) begin
      to_cnt <= to_cnt + 8'd1;
    end
  end

  // Raise the error flag for exactly the DONE cycle that follows an abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= (state == REQ) && !dmem_ack && timeout_hit;
    end
  end

  assign mem_err = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
  assign timeout_hit    = 1'b0;
  assign mem_err        = 1'b0;
`endif

  // Hold the FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Compute the next state of the handshake.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (memop) next_state = REQ;
      REQ:     if (dmem_ack || timeout_hit) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Capture read data on the edge that completes the request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= 32'd0;
    end else if ((state == REQ) && dmem_ack) begin
      rdata_q <= dmem_rdata;
    end
  end

  // Load the writeback slot on non-stalled edges. Insert a bubble otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_data    <= 32'd0;
      wb_rd      <= 4'd0;
      wb_we      <= 1'b0;
      wb_valid   <= 1'b0;
      wb_sig     <= 6'd0;
      wb_br_cond <= 4'd0;
    end else if (!stall) begin
      wb_data    <= (signals[3] && !signals[1]) ? rdata_q : alu;
      wb_rd      <= rd;
      wb_we      <= signals[2] & ~mem_err;
      wb_valid   <= 1'b1;
      wb_sig     <= signals[10:5];
      wb_br_cond <= br_cond;
    end else begin
      wb_we    <= 1'b0;
      wb_valid <= 1'b0;
    end
  end

endmodule
